// File: rtl/issue_pkg.sv
// Shared types for the dual-issue dispatch stage: the buffered instruction entry
// and the register-dependency helper used by the hazard rules.
package issue_pkg;

    localparam int PAYLOAD_W_MAX = 64;
    localparam int REG_W         = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [PAYLOAD_W_MAX-1:0] payload;
        logic [REG_W-1:0]         rd;
        logic [REG_W-1:0]         rj;
        logic [REG_W-1:0]         rk;
        logic                     main_only;
        logic                     is_load;
    } issue_entry_t;

    // True when entry e reads register r; register 0 is never a dependency.
    function automatic logic has_dep(input issue_entry_t e, input logic [REG_W-1:0] r);
        return (r != REG_ZERO) && ((e.rj == r) || (e.rk == r));
    endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Pure combinational issue rules for the two head entries: load-use, pair RAW/WAW,
// pipe-class restriction, EX stall and strict program order.
module issue_hazard_check
    import issue_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  issue_entry_t     h0,
    input  issue_entry_t     h1,
    input  logic [REG_W-1:0] ex_ld,
    input  logic [REG_W-1:0] m1_ld,
    input  logic [CNT_W-1:0] count,
    input  logic             stall_i,
    output logic [1:0]       issue
);

    logic lu0, lu1, raw, waw;
    logic unused_fields;

    assign lu0 = has_dep(h0, ex_ld) || has_dep(h0, m1_ld);
    assign lu1 = has_dep(h1, ex_ld) || has_dep(h1, m1_ld);
    assign raw = has_dep(h1, h0.rd);
    assign waw = (h0.rd != REG_ZERO) && (h0.rd == h1.rd);

    // Pipe 0 accepts every class, so H0's class and both payloads are irrelevant here.
    assign unused_fields = ^{h0.payload, h0.main_only, h1.payload};

    // H1 may only go alongside H0; a load is always main-only.
    assign issue[0] = (count != '0) && !stall_i && !lu0;
    assign issue[1] = issue[0] && (count >= CNT_W'(2)) && !(h1.main_only || h1.is_load)
                      && !lu1 && !raw && !waw;

endmodule

// File: rtl/issue_buffer.sv
// Dual-issue in-order dispatch buffer: circular FIFO of decoded instructions,
// a two-stage load scoreboard, and issue to pipe 0 (oldest) and pipe 1 (next).
module issue_buffer
    import issue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic [1:0]                 in_valid_i,
    input  logic [1:0][PAYLOAD_W-1:0]  in_payload_i,
    input  logic [1:0][REG_W-1:0]      in_rd_i,
    input  logic [1:0][REG_W-1:0]      in_rj_i,
    input  logic [1:0][REG_W-1:0]      in_rk_i,
    input  logic [1:0]                 in_main_only_i,
    input  logic [1:0]                 in_is_load_i,
    output logic                       in_ready_o,
    output logic [1:0]                 issue_o,
    output logic [1:0][PAYLOAD_W-1:0]  issue_payload_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    issue_entry_t           mem [DEPTH];
    issue_entry_t           in_e [2];
    issue_entry_t           h0, h1;
    logic [PTR_W-1:0]       head, tail, head_p1, tail_p1;
    logic [CNT_W-1:0]       count;
    logic [REG_W-1:0]       ex_ld, m1_ld;
    logic [1:0]             hz_issue, enq_n, iss_n;
    logic                   enq_ok;

    // Handshake: in_ready_o depends only on registered count (room for a full pair);
    // slot s is taken when in_valid_i[s] & in_ready_o & ~flush_i. Slot 1 never
    // comes without slot 0. Issue has no ready: issue_o[p] is the transfer itself.
    assign in_ready_o = !rst && (count <= CNT_W'(DEPTH - 2));
    assign enq_ok     = in_ready_o && !flush_i;
    assign enq_n      = enq_ok ? ({1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]}) : 2'd0;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);
    assign h0      = mem[head];
    assign h1      = mem[head_p1];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            in_e[s]           = '0;
            in_e[s].payload   = PAYLOAD_W_MAX'(in_payload_i[s]);
            in_e[s].rd        = in_rd_i[s];
            in_e[s].rj        = in_rj_i[s];
            in_e[s].rk        = in_rk_i[s];
            in_e[s].main_only = in_main_only_i[s] || in_is_load_i[s];
            in_e[s].is_load   = in_is_load_i[s];
        end
    end

    issue_hazard_check #(.CNT_W(CNT_W)) u_hazard (
        .h0      (h0),
        .h1      (h1),
        .ex_ld   (ex_ld),
        .m1_ld   (m1_ld),
        .count   (count),
        .stall_i (stall_i),
        .issue   (hz_issue)
    );

    assign issue_o            = (rst || flush_i) ? 2'b00 : hz_issue;
    assign iss_n              = {1'b0, issue_o[0]} + {1'b0, issue_o[1]};
    assign issue_payload_o[0] = issue_o[0] ? h0.payload[PAYLOAD_W-1:0] : '0;
    assign issue_payload_o[1] = issue_o[1] ? h1.payload[PAYLOAD_W-1:0] : '0;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (enq_ok && in_valid_i[0]) mem[tail]    <= in_e[0];
        if (enq_ok && in_valid_i[1]) mem[tail_p1] <= in_e[1];
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ex_ld <= REG_ZERO;
            m1_ld <= REG_ZERO;
        end else begin
            tail  <= tail + PTR_W'(enq_n);
            head  <= head + PTR_W'(iss_n);
            count <= count + CNT_W'(enq_n) - CNT_W'(iss_n);
            // Only EX and M1 need blocking; M2 onward is covered by forwarding.
            if (!stall_i) begin
                m1_ld <= ex_ld;
                ex_ld <= (issue_o[0] && h0.is_load) ? h0.rd : REG_ZERO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CNT_W'(DEPTH));
            if (enq_ok) assert (in_valid_i != 2'b10);
        end
    end

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: pair hazards, load-use timing, full/wrap drain,
// flush and mid-run reset, each with hand-computed expectations.
module tb_issue_buffer;
    import issue_pkg::*;

    logic                clk;
    logic                rst;
    logic                flush_i;
    logic                stall_i;
    logic [1:0]          in_valid_i;
    logic [1:0][63:0]    in_payload_i;
    logic [1:0][4:0]     in_rd_i, in_rj_i, in_rk_i;
    logic [1:0]          in_main_only_i, in_is_load_i;
    logic                in_ready_o;
    logic [1:0]          issue_o;
    logic [1:0][63:0]    issue_payload_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    issue_entry_t nop;

    issue_buffer #(.DEPTH(8), .PAYLOAD_W(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .stall_i         (stall_i),
        .in_valid_i      (in_valid_i),
        .in_payload_i    (in_payload_i),
        .in_rd_i         (in_rd_i),
        .in_rj_i         (in_rj_i),
        .in_rk_i         (in_rk_i),
        .in_main_only_i  (in_main_only_i),
        .in_is_load_i    (in_is_load_i),
        .in_ready_o      (in_ready_o),
        .issue_o         (issue_o),
        .issue_payload_o (issue_payload_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic issue_entry_t mk(input logic [63:0] p, input logic [4:0] rd,
                                        input logic [4:0] rj, input logic [4:0] rk,
                                        input logic mo, input logic ld);
        issue_entry_t e;
        e           = '0;
        e.payload   = p;
        e.rd        = rd;
        e.rj        = rj;
        e.rk        = rk;
        e.main_only = mo;
        e.is_load   = ld;
        return e;
    endfunction

    // driver tasks
    task automatic put(input logic [1:0] v, input issue_entry_t a, input issue_entry_t b);
        in_valid_i        = v;
        in_payload_i[0]   = a.payload;   in_payload_i[1]   = b.payload;
        in_rd_i[0]        = a.rd;        in_rd_i[1]        = b.rd;
        in_rj_i[0]        = a.rj;        in_rj_i[1]        = b.rj;
        in_rk_i[0]        = a.rk;        in_rk_i[1]        = b.rk;
        in_main_only_i[0] = a.main_only; in_main_only_i[1] = b.main_only;
        in_is_load_i[0]   = a.is_load;   in_is_load_i[1]   = b.is_load;
    endtask

    task automatic idle();
        put(2'b00, nop, nop);
    endtask

    // Check this cycle's outputs mid-cycle, then advance to just after the next edge.
    task automatic obs(input string tag, input logic [1:0] iss, input logic [63:0] p0,
                       input logic [63:0] p1, input logic rdy);
        #2;
        check_eq({tag, "_issue"}, {62'd0, issue_o}, {62'd0, iss});
        check_eq({tag, "_pay0"}, issue_payload_o[0], p0);
        check_eq({tag, "_pay1"}, issue_payload_o[1], p1);
        check_eq({tag, "_ready"}, {63'd0, in_ready_o}, {63'd0, rdy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] e0, e1;
        nop     = '0;
        rst     = 1'b1;
        flush_i = 1'b0;
        stall_i = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // outputs held quiet in reset, input dropped
        put(2'b11, mk(64'hE0, 4, 1, 2, 0, 0), mk(64'hE1, 5, 1, 2, 0, 0));
        obs("rst", 2'b00, 0, 0, 1'b0);
        rst = 1'b0;
        idle();
        obs("post_rst", 2'b00, 0, 0, 1'b1);

        // dual issue of independent ALU ops, one cycle after enqueue
        put(2'b11, mk(64'h11, 4, 1, 2, 0, 0), mk(64'h12, 5, 6, 7, 0, 0));
        obs("dual_enq", 2'b00, 0, 0, 1'b1);
        idle();
        obs("dual", 2'b11, 64'h11, 64'h12, 1'b1);
        obs("dual_empty", 2'b00, 0, 0, 1'b1);

        // RAW within pair
        put(2'b11, mk(64'h21, 4, 1, 2, 0, 0), mk(64'h22, 6, 4, 3, 0, 0));
        obs("raw_enq", 2'b00, 0, 0, 1'b1);
        idle();
        obs("raw_a", 2'b01, 64'h21, 0, 1'b1);
        obs("raw_b", 2'b01, 64'h22, 0, 1'b1);

        // main-only second slot (store)
        put(2'b11, mk(64'h31, 1, 2, 3, 0, 0), mk(64'h32, 0, 4, 5, 1, 0));
        obs("mo_enq", 2'b00, 0, 0, 1'b1);
        idle();
        obs("mo_a", 2'b01, 64'h31, 0, 1'b1);
        obs("mo_b", 2'b01, 64'h32, 0, 1'b1);

        // register 0 creates no hazard
        put(2'b11, mk(64'h41, 0, 1, 2, 0, 0), mk(64'h42, 3, 0, 0, 0, 0));
        obs("r0_enq", 2'b00, 0, 0, 1'b1);
        idle();
        obs("r0", 2'b11, 64'h41, 64'h42, 1'b1);

        // WAW within pair
        put(2'b11, mk(64'h51, 4, 1, 2, 0, 0), mk(64'h52, 4, 6, 7, 0, 0));
        obs("waw_enq", 2'b00, 0, 0, 1'b1);
        idle();
        obs("waw_a", 2'b01, 64'h51, 0, 1'b1);
        obs("waw_b", 2'b01, 64'h52, 0, 1'b1);

        // load-use: blocked in EX and M1 slots, issues on the 3rd cycle
        put(2'b11, mk(64'h61, 8, 2, 0, 1, 1), mk(64'h62, 9, 8, 1, 0, 0));
        obs("lu_enq", 2'b00, 0, 0, 1'b1);
        idle();
        obs("lu_ld", 2'b01, 64'h61, 0, 1'b1);
        obs("lu_ex", 2'b00, 0, 0, 1'b1);
        obs("lu_m1", 2'b00, 0, 0, 1'b1);
        obs("lu_go", 2'b01, 64'h62, 0, 1'b1);

        // load-use with a one-cycle stall in between
        put(2'b11, mk(64'h63, 8, 2, 0, 1, 1), mk(64'h64, 9, 8, 1, 0, 0));
        obs("lus_enq", 2'b00, 0, 0, 1'b1);
        idle();
        obs("lus_ld", 2'b01, 64'h63, 0, 1'b1);
        stall_i = 1'b1;
        obs("lus_stall", 2'b00, 0, 0, 1'b1);
        stall_i = 1'b0;
        obs("lus_ex", 2'b00, 0, 0, 1'b1);
        obs("lus_m1", 2'b00, 0, 0, 1'b1);
        obs("lus_go", 2'b01, 64'h64, 0, 1'b1);

        // fill to 8 under stall (head now at 6, so the drain wraps), then drain
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e0 = 64'h80 + 64'(2 * i);
            e1 = e0 + 64'd1;
            exp_q.push_back(e0);
            exp_q.push_back(e1);
            put(2'b11, mk(e0, 5'(10 + 2 * i), 1, 2, 0, 0), mk(e1, 5'(11 + 2 * i), 1, 2, 0, 0));
            obs("fill", 2'b00, 0, 0, 1'b1);
        end
        put(2'b11, mk(64'hEE, 20, 1, 2, 0, 0), mk(64'hEF, 21, 1, 2, 0, 0));
        obs("full", 2'b00, 0, 0, 1'b0);
        stall_i = 1'b0;
        idle();
        for (int k = 0; k < 4; k++) begin
            e0 = exp_q.pop_front();
            e1 = exp_q.pop_front();
            obs("drain", 2'b11, e0, e1, (k != 0));
        end
        obs("drained", 2'b00, 0, 0, 1'b1);

        // flush with pending load in EX and same-cycle input
        put(2'b01, mk(64'h91, 8, 2, 0, 1, 1), nop);
        obs("fl_enq", 2'b00, 0, 0, 1'b1);
        put(2'b11, mk(64'h92, 9, 8, 1, 0, 0), mk(64'h93, 10, 1, 2, 0, 0));
        obs("fl_ld", 2'b01, 64'h91, 0, 1'b1);
        flush_i = 1'b1;
        stall_i = 1'b1;
        put(2'b11, mk(64'hE2, 14, 1, 2, 0, 0), mk(64'hE3, 15, 1, 2, 0, 0));
        obs("fl_cyc", 2'b00, 0, 0, 1'b1);
        flush_i = 1'b0;
        put(2'b11, mk(64'h94, 9, 8, 1, 0, 0), mk(64'h95, 11, 1, 2, 0, 0));
        obs("fl_after", 2'b00, 0, 0, 1'b1);
        stall_i = 1'b0;
        idle();
        obs("fl_go", 2'b11, 64'h94, 64'h95, 1'b1);
        obs("fl_empty", 2'b00, 0, 0, 1'b1);

        // reset asserted mid-operation behaves like flush
        put(2'b01, mk(64'hA1, 8, 2, 0, 1, 1), nop);
        obs("rs_enq", 2'b00, 0, 0, 1'b1);
        put(2'b11, mk(64'hA2, 9, 8, 1, 0, 0), mk(64'hA3, 12, 1, 2, 0, 0));
        obs("rs_ld", 2'b01, 64'hA1, 0, 1'b1);
        rst     = 1'b1;
        stall_i = 1'b1;
        idle();
        obs("rs_cyc", 2'b00, 0, 0, 1'b0);
        rst = 1'b0;
        put(2'b11, mk(64'hA4, 9, 8, 1, 0, 0), mk(64'hA5, 13, 1, 2, 0, 0));
        obs("rs_after", 2'b00, 0, 0, 1'b1);
        stall_i = 1'b0;
        idle();
        obs("rs_go", 2'b11, 64'hA4, 64'hA5, 1'b1);
        obs("rs_empty", 2'b00, 0, 0, 1'b1);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
